altera_up_sync_fifo_sv: RTL and testbench

//  Single-clock synchronous FIFO with show-ahead (first-word-fall-through) read port.

---
 rtl/altera_up_sync_fifo_sv.sv | 63 ++++++
 tb/tb_altera_up_sync_fifo_sv.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/altera_up_sync_fifo_sv.sv
// Single-clock show-ahead FIFO: the head word is presented combinationally on read_data
// and is popped at the edge where read_en is high. Occupancy, empty and full come from one counter.
module altera_up_sync_fifo_sv #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  fifo_is_empty,
  output logic                  fifo_is_full,
  output logic [ADDR_WIDTH-1:0] words_used
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_accept;
  logic                  rd_accept;

  // A write while full is only taken when the head is popped in the same cycle.
  assign wr_accept = write_en & (~fifo_is_full | read_en);
  assign rd_accept = read_en & ~fifo_is_empty;

  assign fifo_is_empty = (count == '0);
  assign fifo_is_full  = (count == FULL_COUNT);
  assign words_used    = count[ADDR_WIDTH-1:0];
  assign read_data     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_altera_up_sync_fifo_sv.sv
// Directed bench for altera_up_sync_fifo_sv with depth 64: ordering, full/empty boundaries,
// the delay-line access pattern, simultaneous push/pop when full, and reset during a fill.
module tb_altera_up_sync_fifo_sv;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [23:0] write_data;
  logic        read_en;
  logic [23:0] read_data;
  logic        fifo_is_empty;
  logic        fifo_is_full;
  logic [5:0]  words_used;

  int checks = 0;
  int errors = 0;

  altera_up_sync_fifo_sv #(.DATA_WIDTH(24), .ADDR_WIDTH(6), .DATA_DEPTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .write_en      (write_en),
    .write_data    (write_data),
    .read_en       (read_en),
    .read_data     (read_data),
    .fifo_is_empty (fifo_is_empty),
    .fifo_is_full  (fifo_is_full),
    .words_used    (words_used)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; write_en = 1'b0; read_en = 1'b0; write_data = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; write_en = 1'b0; read_en = 1'b0; write_data = '0;
    step();
    step();
    reset = 1'b0;
    checks++; if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifo_is_empty); end
    checks++; if (fifo_is_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_is_full); end
    checks++; if (words_used !== 6'd0) begin errors++; $display("FAIL reset_words got %0d exp 0", words_used); end
  endtask

  task automatic test_basic();
    write_en = 1'b1; write_data = 24'd1;
    step();
    checks++; if (read_data !== 24'd1) begin errors++; $display("FAIL basic_first_latency got %0d exp 1", read_data); end
    checks++; if (fifo_is_empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty got %b exp 0", fifo_is_empty); end
    write_data = 24'd2; step();
    write_data = 24'd3; step();
    write_en = 1'b0;
    checks++; if (words_used !== 6'd3) begin errors++; $display("FAIL basic_words got %0d exp 3", words_used); end
    read_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (read_data !== 24'(i)) begin errors++; $display("FAIL basic_read got %0d exp %0d", read_data, i); end
      step();
    end
    read_en = 1'b0;
    checks++; if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after got %b exp 1", fifo_is_empty); end
  endtask

  task automatic test_fill();
    write_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      write_data = 24'(i);
      step();
      if (i == 62) begin
        checks++; if (words_used !== 6'd63) begin errors++; $display("FAIL fill_words63 got %0d exp 63", words_used); end
        checks++; if (fifo_is_full !== 1'b0) begin errors++; $display("FAIL fill_not_full63 got %b exp 0", fifo_is_full); end
      end
    end
    checks++; if (words_used !== 6'd0) begin errors++; $display("FAIL fill_words_full got %0d exp 0", words_used); end
    checks++; if (fifo_is_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", fifo_is_full); end
    write_data = 24'd999;
    step();
    write_en = 1'b0;
    checks++; if (fifo_is_full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", fifo_is_full); end
    checks++; if (read_data !== 24'd0) begin errors++; $display("FAIL overflow_head got %0d exp 0", read_data); end
    read_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++; if (read_data !== 24'(i)) begin errors++; $display("FAIL fill_read got %0d exp %0d", read_data, i); end
      step();
    end
    read_en = 1'b0;
    checks++; if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL fill_empty_after got %b exp 1", fifo_is_empty); end
    checks++; if (words_used !== 6'd0) begin errors++; $display("FAIL fill_words_after got %0d exp 0", words_used); end
  endtask

  task automatic test_filter();
    write_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      write_data = 24'(1000 + k);
      read_en = (k >= 63);
      if (k >= 63) begin
        checks++; if (words_used !== 6'd63) begin errors++; $display("FAIL filter_words got %0d exp 63", words_used); end
        checks++; if (read_data !== 24'(1000 + k - 63)) begin errors++; $display("FAIL filter_pop got %0d exp %0d", read_data, 1000 + k - 63); end
      end
      step();
      checks++; if (fifo_is_full !== 1'b0) begin errors++; $display("FAIL filter_full got %b exp 0", fifo_is_full); end
    end
    write_en = 1'b0; read_en = 1'b0;
    checks++; if (words_used !== 6'd63) begin errors++; $display("FAIL filter_words_end got %0d exp 63", words_used); end
    do_reset();
  endtask

  task automatic test_full_rw();
    write_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      write_data = 24'(200 + i);
      step();
    end
    checks++; if (fifo_is_full !== 1'b1) begin errors++; $display("FAIL fullrw_full_before got %b exp 1", fifo_is_full); end
    write_data = 24'd99; read_en = 1'b1;
    checks++; if (read_data !== 24'd200) begin errors++; $display("FAIL fullrw_head got %0d exp 200", read_data); end
    step();
    write_en = 1'b0;
    checks++; if (fifo_is_full !== 1'b1) begin errors++; $display("FAIL fullrw_full_after got %b exp 1", fifo_is_full); end
    checks++; if (words_used !== 6'd0) begin errors++; $display("FAIL fullrw_words got %0d exp 0", words_used); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (read_data !== ((i == 63) ? 24'd99 : 24'(201 + i))) begin
        errors++; $display("FAIL fullrw_pop got %0d exp %0d", read_data, (i == 63) ? 99 : 201 + i);
      end
      step();
    end
    read_en = 1'b0;
    checks++; if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b exp 1", fifo_is_empty); end
  endtask

  task automatic test_underflow_and_reset();
    read_en = 1'b1; write_en = 1'b0;
    step();
    checks++; if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got %b exp 1", fifo_is_empty); end
    checks++; if (words_used !== 6'd0) begin errors++; $display("FAIL underflow_words got %0d exp 0", words_used); end
    write_en = 1'b1; write_data = 24'd77;
    step();
    read_en = 1'b0; write_en = 1'b0;
    checks++; if (words_used !== 6'd1) begin errors++; $display("FAIL empty_rw_words got %0d exp 1", words_used); end
    checks++; if (read_data !== 24'd77) begin errors++; $display("FAIL empty_rw_data got %0d exp 77", read_data); end
    write_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_data = 24'(300 + i);
      step();
    end
    checks++; if (words_used !== 6'd10) begin errors++; $display("FAIL midfill_words got %0d exp 10", words_used); end
    reset = 1'b1; read_en = 1'b1;
    step();
    reset = 1'b0; write_en = 1'b0; read_en = 1'b0;
    checks++; if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got %b exp 1", fifo_is_empty); end
    checks++; if (fifo_is_full !== 1'b0) begin errors++; $display("FAIL midreset_full got %b exp 0", fifo_is_full); end
    checks++; if (words_used !== 6'd0) begin errors++; $display("FAIL midreset_words got %0d exp 0", words_used); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_filter();
    test_full_rw();
    test_underflow_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
